// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending-write scoreboard so decode can stall on RAW hazards by itself.
module regfile_mp #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter int NRD        = 2,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rbusy_o,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic                rsv_i,
    input  logic [AW-1:0]       rsv_addr_i,
    output logic                rsv_ack_o,
    input  logic                flush_i,
    output logic [NREGS-1:0]    busy_vec_o
);

    logic [XLEN-1:0]  regs_r [NREGS];
    logic [NREGS-1:0] busy_r;
    logic             wr_en_s;
    logic             rsv_zero_s;
    logic             rsv_ack_s;
    logic             rsv_set_s;

    // Writes aimed at the hardwired zero register are discarded.
    always_comb begin
        if (ZERO_REG && (waddr_i == {AW{1'b0}})) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = we_i;
        end
    end

    // A reservation is accepted when the target is free or is being written
    // back this very cycle; flush suppresses every reservation.
    always_comb begin
        rsv_zero_s = ZERO_REG && (rsv_addr_i == {AW{1'b0}});
        if (rst_i) begin
            rsv_ack_s = 1'b0;
        end else begin
            rsv_ack_s = rsv_i & ~flush_i &
                        (rsv_zero_s | ~busy_r[rsv_addr_i] |
                         (we_i & (waddr_i == rsv_addr_i)));
        end
        rsv_set_s = rsv_ack_s & ~rsv_zero_s;
    end

    // Storage and scoreboard: flush beats reserve, reserve beats write-clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            busy_r <= {NREGS{1'b0}};
        end else begin
            if (wr_en_s) begin
                regs_r[waddr_i] <= wdata_i;
            end
            if (flush_i) begin
                busy_r <= {NREGS{1'b0}};
            end else begin
                for (int i = 0; i < NREGS; i++) begin
                    if (rsv_set_s && (rsv_addr_i == AW'(i))) begin
                        busy_r[i] <= 1'b1;
                    end else if (wr_en_s && (waddr_i == AW'(i))) begin
                        busy_r[i] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;
        logic            hit_s;
        logic            zero_s;

        assign addr_s = raddr_i[k*AW +: AW];

        // Read mux; a matching in-flight write is forwarded and is no longer pending.
        always_comb begin
            hit_s  = BYPASS && we_i && (waddr_i == addr_s);
            zero_s = ZERO_REG && (addr_s == {AW{1'b0}});
            if (rst_i || zero_s) begin
                data_s = {XLEN{1'b0}};
                busy_s = 1'b0;
            end else if (hit_s) begin
                data_s = wdata_i;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rdata_o[k*XLEN +: XLEN] = data_s;
        assign rbusy_o[k]              = busy_s;
    end

    assign rsv_ack_o  = rsv_ack_s;
    assign busy_vec_o = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus and are compared every cycle against an array-based model.
module tb_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata_a, rdata_b;
    logic [NRD-1:0]      rbusy_a, rbusy_b;
    logic                we, rsv, flush;
    logic [AW-1:0]       waddr, rsv_addr;
    logic [XLEN-1:0]     wdata;
    logic                ack_a, ack_b;
    logic [NREGS-1:0]    bvec_a, bvec_b;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [XLEN-1:0]  m_reg [NREGS];
    logic [NREGS-1:0] m_busy;

    regfile_mp dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
        .rsv_ack_o(ack_a), .flush_i(flush), .busy_vec_o(bvec_a)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr),
        .rsv_ack_o(ack_b), .flush_i(flush), .busy_vec_o(bvec_b)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] port_addr(int k);
        return raddr[k*AW +: AW];
    endfunction

    function automatic logic [XLEN-1:0] exp_rdata(logic [AW-1:0] a, bit byp);
        if (rst || a == AW'(0)) return {XLEN{1'b0}};
        if (byp && we && waddr == a) return wdata;
        return m_reg[a];
    endfunction

    function automatic logic exp_rbusy(logic [AW-1:0] a, bit byp);
        if (rst || a == AW'(0)) return 1'b0;
        if (byp && we && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ack();
        if (rst || !rsv || flush) return 1'b0;
        return (rsv_addr == AW'(0)) || !m_busy[rsv_addr] || (we && waddr == rsv_addr);
    endfunction

    function automatic logic [NREGS-1:0] next_busy();
        logic [NREGS-1:0] b = m_busy;
        if (flush) return {NREGS{1'b0}};
        if (we && waddr != AW'(0)) b[waddr] = 1'b0;
        if (exp_ack() && rsv_addr != AW'(0)) b[rsv_addr] = 1'b1;
        return b;
    endfunction

    // Reference model state, advanced on each edge from the spec rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m_reg[i] <= {XLEN{1'b0}};
            m_busy <= {NREGS{1'b0}};
        end else begin
            if (we && waddr != AW'(0)) m_reg[waddr] <= wdata;
            m_busy <= next_busy();
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NRD; k++) begin
            chk($sformatf("rdata%0d", k), rdata_a[k*XLEN +: XLEN], exp_rdata(port_addr(k), 1'b1));
            chk($sformatf("rdata_nb%0d", k), rdata_b[k*XLEN +: XLEN], exp_rdata(port_addr(k), 1'b0));
            chk($sformatf("rbusy%0d", k), 32'(rbusy_a[k]), 32'(exp_rbusy(port_addr(k), 1'b1)));
            chk($sformatf("rbusy_nb%0d", k), 32'(rbusy_b[k]), 32'(exp_rbusy(port_addr(k), 1'b0)));
        end
        chk("rsv_ack", 32'(ack_a), 32'(exp_ack()));
        chk("rsv_ack_nb", 32'(ack_b), 32'(exp_ack()));
        chk("busy_vec", bvec_a, m_busy);
        chk("busy_vec_nb", bvec_b, m_busy);
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) check_all();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv = 1'b0; flush = 1'b0;
    endtask

    task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; we = 1'b0; rsv = 1'b0; flush = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; rsv_addr = '0;
        #2 rst = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Reset sweep of every address on both ports.
        for (int a = 0; a < NREGS; a++) begin
            set_rd(AW'(a), AW'(NREGS - 1 - a));
            #2;
            chk("sweep_rd0", rdata_a[XLEN-1:0], 32'h0);
            chk("sweep_rd1", rdata_a[2*XLEN-1:XLEN], 32'h0);
            chk("sweep_busy", 32'(rbusy_a), 32'h0);
            chk("sweep_bvec", bvec_a, 32'h0);
            tick();
        end

        // Write x5 with same-cycle read, then read next cycle.
        set_rd(5'd5, 5'd5); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        #2;
        chk("bypass_rd0", rdata_a[XLEN-1:0], 32'hDEADBEEF);
        chk("nobypass_rd0", rdata_b[XLEN-1:0], 32'h0);
        tick(); idle(); #2;
        chk("x5_rd0", rdata_a[XLEN-1:0], 32'hDEADBEEF);
        chk("x5_rd1", rdata_a[2*XLEN-1:XLEN], 32'hDEADBEEF);
        chk("x5_nb_rd1", rdata_b[2*XLEN-1:XLEN], 32'hDEADBEEF);
        tick();

        // Zero register: write and reserve are both harmless.
        set_rd(5'd0, 5'd0); we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        rsv = 1'b1; rsv_addr = 5'd0;
        #2;
        chk("x0_ack", 32'(ack_a), 32'h1);
        chk("x0_rd_same", rdata_a[XLEN-1:0], 32'h0);
        tick(); idle(); #2;
        chk("x0_rd", rdata_a[XLEN-1:0], 32'h0);
        chk("x0_bvec", bvec_a, 32'h0);
        tick();

        // Reserve x7, re-reserve refused, write clears, write+reserve keeps busy.
        set_rd(5'd7, 5'd7); rsv = 1'b1; rsv_addr = 5'd7;
        #2 chk("x7_ack1", 32'(ack_a), 32'h1);
        tick(); #2;
        chk("x7_rbusy", 32'(rbusy_a[0]), 32'h1);
        chk("x7_ack2", 32'(ack_a), 32'h0);
        tick(); idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'h55;
        tick(); idle(); #2;
        chk("x7_cleared", bvec_a, 32'h0);
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'h55; rsv = 1'b1; rsv_addr = 5'd7;
        #2 chk("x7_ack3", 32'(ack_a), 32'h1);
        tick(); idle(); #2;
        chk("x7_bvec", bvec_a, 32'h0000_0080);
        chk("x7_data", rdata_a[XLEN-1:0], 32'h55);
        chk("x7_rbusy2", 32'(rbusy_a[0]), 32'h1);
        tick();

        // Reserve x3, x4, x9 then flush overrides a reserve of x10.
        rsv = 1'b1; rsv_addr = 5'd3; tick();
        rsv_addr = 5'd4; tick();
        rsv_addr = 5'd9; tick();
        flush = 1'b1; rsv_addr = 5'd10;
        #2;
        chk("flush_ack", 32'(ack_a), 32'h0);
        chk("pre_flush_bvec", bvec_a, 32'h0000_0298);
        tick(); idle(); #2;
        chk("flush_bvec", bvec_a, 32'h0);
        tick();

        // Asynchronous reset mid-cycle with live write/reserve requests.
        we = 1'b1; waddr = 5'd2; wdata = 32'hA5A5A5A5; tick(); idle();
        rsv = 1'b1; rsv_addr = 5'd6; tick(); idle();
        set_rd(5'd2, 5'd6);
        #2;
        chk("x2_rd", rdata_a[XLEN-1:0], 32'hA5A5A5A5);
        chk("x6_bvec", bvec_a, 32'h0000_0040);
        chk("x6_rbusy", 32'(rbusy_a[1]), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_rd", rdata_a[XLEN-1:0], 32'h0);
        chk("arst_bvec", bvec_a, 32'h0);
        we = 1'b1; waddr = 5'd2; wdata = 32'hFFFFFFFF; rsv = 1'b1; rsv_addr = 5'd6;
        #1;
        chk("arst_bypass_rd", rdata_a[XLEN-1:0], 32'h0);
        chk("arst_ack", 32'(ack_a), 32'h0);
        check_all();
        tick(); idle(); rst = 1'b0;
        tick();

        // Randomised traffic with occasional flushes and asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            we       = 1'($urandom_range(0, 1));
            waddr    = rand_addr();
            wdata    = $urandom();
            rsv      = ($urandom_range(0, 2) != 0);
            rsv_addr = rand_addr();
            flush    = ($urandom_range(0, 15) == 0);
            set_rd(rand_addr(), rand_addr());
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 check_all();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
